// File: rtl/control_fsm_multicycle.sv
// Multicycle control unit for lw/sw/add/sub/addi. Sequences the datapath strobes and selects
// for one instruction at a time, traps illegal encodings and counts retired instructions.
module control_fsm_multicycle #(
    parameter int DATA_WIDTH  = 64,
    parameter int COUNT_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [31:0]            instruction,
    input  logic                   instrValid,
    output logic                   instrReady,
    output logic                   writeEnable_Registers,
    output logic                   writeEnable_DataMemory,
    output logic                   muxSelect_SumVsReadData,
    output logic                   muxSelect_ImmVsDataout2,
    output logic                   SumOrSub,
    output logic [4:0]             rs1Addr,
    output logic [4:0]             rs2Addr,
    output logic [4:0]             rdAddr,
    output logic [DATA_WIDTH-1:0]  immediate,
    output logic                   illegalInstr,
    output logic [COUNT_WIDTH-1:0] retiredCount
);

    typedef enum logic [2:0] {S_IDLE, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP} state_t;
    typedef enum logic [2:0] {OP_ILL, OP_LW, OP_SW, OP_ADD, OP_SUB, OP_ADDI} op_t;

    function automatic op_t decode_op(input logic [31:0] ins);
        op_t op;
        op = OP_ILL;
        if (ins[6:0] == 7'b0000011 && ins[14:12] == 3'b010)
            op = OP_LW;
        else if (ins[6:0] == 7'b0100011 && ins[14:12] == 3'b010)
            op = OP_SW;
        else if (ins[6:0] == 7'b0110011 && ins[14:12] == 3'b000 && ins[31:25] == 7'b0000000)
            op = OP_ADD;
        else if (ins[6:0] == 7'b0110011 && ins[14:12] == 3'b000 && ins[31:25] == 7'b0100000)
            op = OP_SUB;
        else if (ins[6:0] == 7'b0010011 && ins[14:12] == 3'b000)
            op = OP_ADDI;
        return op;
    endfunction

    function automatic logic [DATA_WIDTH-1:0] imm_of(input op_t op, input logic [31:0] ins);
        logic [DATA_WIDTH-1:0] imm;
        imm = '0;
        case (op)
            OP_LW, OP_ADDI: imm = {{(DATA_WIDTH-12){ins[31]}}, ins[31:20]};
            OP_SW:          imm = {{(DATA_WIDTH-12){ins[31]}}, ins[31:25], ins[11:7]};
            default:        imm = '0;
        endcase
        return imm;
    endfunction

    state_t                 r_state;
    op_t                    r_op;
    logic                   r_ready;
    logic                   r_we_reg;
    logic                   r_we_mem;
    logic                   r_sel_sum;
    logic                   r_sel_dout2;
    logic                   r_sub;
    logic                   r_illegal;
    logic [4:0]             r_rs1;
    logic [4:0]             r_rs2;
    logic [4:0]             r_rd;
    logic [DATA_WIDTH-1:0]  r_imm;
    logic [COUNT_WIDTH-1:0] r_count;

    op_t  w_op;
    logic w_accept;

    assign w_op     = decode_op(instruction);
    assign w_accept = instrValid && r_ready;

    // NOTE: every state bit sits on the async reset so a mid-instruction reset drops the
    // strobes at once; non-blocking assignments keep all registers sampling the same edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            r_op        <= OP_ILL;
            r_ready     <= 1'b1;
            r_we_reg    <= 1'b0;
            r_we_mem    <= 1'b0;
            r_sel_sum   <= 1'b0;
            r_sel_dout2 <= 1'b0;
            r_sub       <= 1'b0;
            r_illegal   <= 1'b0;
            r_rs1       <= '0;
            r_rs2       <= '0;
            r_rd        <= '0;
            r_imm       <= '0;
            r_count     <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_state     <= S_DECODE;
                        r_ready     <= 1'b0;
                        r_op        <= w_op;
                        r_rs1       <= instruction[19:15];
                        r_rs2       <= instruction[24:20];
                        r_rd        <= (w_op == OP_SW) ? 5'd0 : instruction[11:7];
                        r_imm       <= imm_of(w_op, instruction);
                        r_sel_sum   <= w_op inside {OP_ADD, OP_SUB, OP_ADDI};
                        r_sel_dout2 <= w_op inside {OP_ADD, OP_SUB};
                        r_sub       <= (w_op == OP_SUB);
                    end
                end
                S_DECODE: begin
                    if (r_op == OP_ILL) begin
                        r_state   <= S_TRAP;
                        r_illegal <= 1'b1;
                    end else begin
                        r_state   <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (r_op == OP_LW || r_op == OP_SW) begin
                        r_state  <= S_MEM;
                        r_we_mem <= (r_op == OP_SW);
                    end else begin
                        r_state  <= S_WB;
                        r_we_reg <= 1'b1;
                    end
                end
                S_MEM: begin
                    r_we_mem <= 1'b0;
                    if (r_op == OP_LW) begin
                        r_state  <= S_WB;
                        r_we_reg <= 1'b1;
                    end else begin
                        r_state     <= S_IDLE;
                        r_ready     <= 1'b1;
                        r_count     <= r_count + COUNT_WIDTH'(1);
                        r_sel_sum   <= 1'b0;
                        r_sel_dout2 <= 1'b0;
                        r_sub       <= 1'b0;
                    end
                end
                S_WB: begin
                    r_we_reg    <= 1'b0;
                    r_state     <= S_IDLE;
                    r_ready     <= 1'b1;
                    r_count     <= r_count + COUNT_WIDTH'(1);
                    r_sel_sum   <= 1'b0;
                    r_sel_dout2 <= 1'b0;
                    r_sub       <= 1'b0;
                end
                S_TRAP: begin
                    r_illegal <= 1'b0;
                    r_state   <= S_IDLE;
                    r_ready   <= 1'b1;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_ready <= 1'b1;
                end
            endcase
        end
    end

    assign instrReady              = r_ready;
    assign writeEnable_Registers   = r_we_reg;
    assign writeEnable_DataMemory  = r_we_mem;
    assign muxSelect_SumVsReadData = r_sel_sum;
    assign muxSelect_ImmVsDataout2 = r_sel_dout2;
    assign SumOrSub                = r_sub;
    assign rs1Addr                 = r_rs1;
    assign rs2Addr                 = r_rs2;
    assign rdAddr                  = r_rd;
    assign immediate               = r_imm;
    assign illegalInstr            = r_illegal;
    assign retiredCount            = r_count;

endmodule
